bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared 32-bit SoC bus (BUS_addr/BUS_data/BUS_req/BUS_ready/BUS_RW).
//  Each master (CPU I/D ports, DMA engines) raises its DMA[i] request and drives the bus only while grant[i] is high.
//  Adds a bus-idle turnaround cycle, fair rotation and a ready-timeout watchdog, so a hung slave cannot lock the SoC.
// PARAMETERS
//  N_MASTERS   8    number of request/grant pairs (2..8)
//  TIMEOUT     255  max cycles BUS_req may stay high under one grant without BUS_ready (1..65535)
//  TO_W        16   watchdog counter width; must hold TIMEOUT
// PORTS
//  clk         in   1          system clock; all state on posedge clk
//  clr_n       in   1          asynchronous, active-low reset
//  DMA         in   N_MASTERS  request lines; level, held by master for its whole tenure
//  BUS_req     in   1          transfer strobe from current owner
//  BUS_ready   in   1          transfer-complete from addressed slave
//  grant       out  N_MASTERS  one-hot (or zero) bus ownership
//  owner       out  3          index of granted master; valid when bus_busy=1
//  bus_busy    out  1          some grant[i] is high
//  bus_err     out  1          one-cycle pulse on watchdog expiry
//  err_master  out  3          index of master that timed out; holds until next bus_err
// BEHAVIOUR
//  Reset (clr_n=0, async): grant=0, owner=0, bus_busy=0, bus_err=0, err_master=0, state=IDLE,
//   rr_last=N_MASTERS-1 (master 0 wins first), mask=0, wdog=0. Reset mid-tenure drops grant immediately.
//  States: IDLE -> GRANT -> TURN -> IDLE.
//   IDLE: eligible = DMA & ~mask. If nonzero, pick first eligible index searching rr_last+1 upward, wrapping mod N_MASTERS;
//         next cycle grant[pick]=1, owner=pick, rr_last=pick, state=GRANT. Latency request->grant = 1 cycle.
//   GRANT: grant held while DMA[owner]=1. Other requests never preempt.
//         DMA[owner] falls -> grant=0 next cycle, state=TURN.
//   TURN: exactly one cycle with grant=0 (bus turnaround, no two drivers), then IDLE. Back-to-back tenures
//         therefore see request->grant of 1 cycle after the idle cycle; minimum 2 dead cycles between owners.
//  Watchdog: in GRANT, wdog increments each cycle BUS_req=1 && BUS_ready=0; clears on BUS_ready=1, on BUS_req=0,
//   and on entering GRANT. When wdog reaches TIMEOUT: bus_err=1 for one cycle, err_master=owner, mask[owner]=1,
//   grant=0, state=TURN. Saturating; never wraps.
//  Mask: mask[i] clears on the cycle DMA[i]=0 is sampled; a timed-out master must drop and re-raise its request.
//  Simultaneous: DMA[owner] falling and wdog expiry in same cycle -> expiry wins (bus_err pulses, mask set; mask
//   clears next cycle since DMA is low). BUS_ready and expiry same cycle -> ready wins, no error.
//  Requests that rise/fall while in TURN are just sampled in IDLE; a request raised and dropped
//   within GRANT/TURN of another master is lost (masters must hold).
//  All outputs registered; no combinational path input->output.
// STRUCTURE
//  Shared package bus_pkg: state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2), MAX_MASTERS=8, OWNER_W=3.
//  One sub-module: rr_pick (combinational) -- inputs eligible[N], rr_last; outputs pick index and valid.
//  Top: FSM, owner/grant regs, watchdog counter, mask register.
// TESTING
//  1 Reset, DMA=8'h01 -> grant=8'h01 one cycle later, owner=0, bus_busy=1; drop DMA -> grant=0, 1 TURN cycle.
//  2 DMA=8'h05 held, each master drops after 3 cycles and re-raises -> grants alternate 0,2,0,2; >=2 idle cycles between.
//  3 Owner 1 holds BUS_req=1, BUS_ready=0 for TIMEOUT cycles -> bus_err pulse, err_master=1, grant=0; master 1 stays
//    ignored while DMA[1] high; drop/re-raise -> granted again.
//  4 BUS_ready asserted on cycle TIMEOUT-1 each transfer -> no bus_err over 1000 transfers.
//  5 All 8 requesting continuously with 1-cycle tenures -> grant order 0..7,0.. ; no two grant bits ever high (assertion).
//  6 clr_n pulsed low mid-tenure between clock edges -> grant=0 at once; after release master 0 wins first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the SoC bus arbiter: FSM encoding and index widths.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int MAX_MASTERS = 8;
  localparam int OWNER_W     = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible index strictly after rr_last_i, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 8
) (
  input  logic [N_MASTERS-1:0] eligible_i,
  input  logic [OWNER_W-1:0]   rr_last_i,
  output logic [OWNER_W-1:0]   pick_o,
  output logic                 valid_o
);

  logic [OWNER_W-1:0] idx;

  // Searching offsets 1..N puts the last winner at lowest priority.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = OWNER_W'((int'(rr_last_i) + k) % N_MASTERS);
      if (!valid_o && eligible_i[idx]) begin
        valid_o = 1'b1;
        pick_o  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a turnaround cycle between owners and a
// ready-timeout watchdog that evicts and masks a master stuck on a hung slave.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 8,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [N_MASTERS-1:0] DMA,
  input  logic                 BUS_req,
  input  logic                 BUS_ready,
  output logic [N_MASTERS-1:0] grant,
  output logic [OWNER_W-1:0]   owner,
  output logic                 bus_busy,
  output logic                 bus_err,
  output logic [OWNER_W-1:0]   err_master
);

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   rr_last_q, rr_last_d;
  logic [OWNER_W-1:0]   err_master_q, err_master_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [TO_W-1:0]      wdog_q, wdog_d;

  logic [N_MASTERS-1:0] eligible;
  logic [OWNER_W-1:0]   pick;
  logic                 pick_vld;
  logic                 owner_req;
  logic                 stall;
  logic                 expire;

  assign eligible  = DMA & ~mask_q;
  assign owner_req = DMA[owner_q];
  assign stall     = (state_q == GRANT) && BUS_req && !BUS_ready;
  // A ready in the expiry cycle removes the stall, so ready wins.
  assign expire    = stall && (wdog_q == TO_W'(TIMEOUT - 1));

  rr_pick #(
    .N_MASTERS(N_MASTERS)
  ) u_rr_pick (
    .eligible_i(eligible),
    .rr_last_i (rr_last_q),
    .pick_o    (pick),
    .valid_o   (pick_vld)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   if (expire || !owner_req) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    err_master_d = err_master_q;
    wdog_d       = wdog_q;
    mask_d       = mask_q & DMA;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d   = N_MASTERS'(1) << pick;
          owner_d   = pick;
          rr_last_d = pick;
          busy_d    = 1'b1;
          wdog_d    = '0;
        end
      end
      GRANT: begin
        // Expiry is checked first so it beats a simultaneous request drop.
        if (expire) begin
          grant_d      = '0;
          busy_d       = 1'b0;
          err_d        = 1'b1;
          err_master_d = owner_q;
          mask_d       = mask_d | (N_MASTERS'(1) << owner_q);
          wdog_d       = TO_W'(TIMEOUT);
        end else if (!owner_req) begin
          grant_d = '0;
          busy_d  = 1'b0;
          wdog_d  = '0;
        end else if (stall) begin
          wdog_d = wdog_q + TO_W'(1);
        end else begin
          wdog_d = '0;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      grant_q      <= '0;
      owner_q      <= '0;
      rr_last_q    <= OWNER_W'(N_MASTERS - 1);
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_master_q <= '0;
      mask_q       <= '0;
      wdog_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_master_q <= err_master_d;
      mask_q       <= mask_d;
      wdog_q       <= wdog_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign bus_busy   = busy_q;
  assign bus_err    = err_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, rotation, turnaround, watchdog and reset.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int N  = 8;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [N-1:0] DMA;
  logic         BUS_req;
  logic         BUS_ready;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         bus_busy;
  logic         bus_err;
  logic [2:0]   err_master;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT  (TO),
    .TO_W     (16)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .DMA       (DMA),
    .BUS_req   (BUS_req),
    .BUS_ready (BUS_ready),
    .grant     (grant),
    .owner     (owner),
    .bus_busy  (bus_busy),
    .bus_err   (bus_err),
    .err_master(err_master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clr_n     = 1'b0;
    DMA       = '0;
    BUS_req   = 1'b0;
    BUS_ready = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  task automatic wait_grant(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cyc++;
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr_n     = 1'b0;
    DMA       = 8'hFF;
    BUS_req   = 1'b0;
    BUS_ready = 1'b0;
    #2;
    tick();
    tests++;
    if ({grant, owner, bus_busy, bus_err, err_master} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: grant=%h owner=%0d busy=%b err=%b err_master=%0d, all must be 0",
               grant, owner, bus_busy, bus_err, err_master);
    end
    DMA = '0;
  endtask

  task automatic test_single();
    apply_reset();
    DMA = 8'h01;
    tick();
    tests++;
    if (grant !== 8'h01 || owner !== 3'd0 || bus_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant=%h owner=%0d busy=%b, need 01/0/1", grant, owner, bus_busy);
    end
    DMA = 8'h00;
    tick();
    tests++;
    if (grant !== 8'h00 || bus_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release: grant=%h busy=%b, need 00/0", grant, bus_busy);
    end
    DMA = 8'h01;
    tick();
    tests++;
    if (grant !== 8'h00) begin
      fails++;
      $display("FAIL single_turn: grant=%h, need 00 during turnaround", grant);
    end
    tick();
    tests++;
    if (grant !== 8'h01) begin
      fails++;
      $display("FAIL single_regrant: grant=%h, need 01", grant);
    end
    DMA = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_alternate();
    int         cyc;
    bit         ok;
    int         exp_o;
    logic [7:0] e;
    apply_reset();
    DMA = 8'h05;
    for (int t = 0; t < 4; t++) begin
      exp_o = (t % 2) * 2;
      e     = 8'h01 << exp_o;
      wait_grant(cyc, ok);
      tests++;
      if (!ok || owner !== 3'(exp_o) || grant !== e) begin
        fails++;
        $display("FAIL alt_owner%0d: owner=%0d grant=%h, need %0d/%h", t, owner, grant, exp_o, e);
      end
      if (t > 0) begin
        tests++;
        if (cyc != 2) begin
          fails++;
          $display("FAIL alt_gap%0d: idle cycles=%0d, need 2", t, cyc);
        end
      end
      tick();
      tick();
      tests++;
      if (grant !== e) begin
        fails++;
        $display("FAIL alt_hold%0d: grant=%h, need %h", t, grant, e);
      end
      DMA[exp_o] = 1'b0;
      tick();
      DMA[exp_o] = 1'b1;
    end
    DMA = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    bit early;
    bit leak;
    apply_reset();
    DMA = 8'h02;
    wait_grant(cyc, ok);
    tests++;
    if (!ok || owner !== 3'd1) begin
      fails++;
      $display("FAIL to_grant: owner=%0d ok=%b, need 1", owner, ok);
    end
    BUS_req   = 1'b1;
    BUS_ready = 1'b0;
    early     = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (grant !== 8'h02 || bus_err !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL to_early: error/eviction before %0d stall cycles, grant=%h err=%b", TO, grant, bus_err);
    end
    tick();
    tests++;
    if (bus_err !== 1'b1 || err_master !== 3'd1 || grant !== 8'h00) begin
      fails++;
      $display("FAIL to_expire: err=%b err_master=%0d grant=%h, need 1/1/00", bus_err, err_master, grant);
    end
    BUS_req = 1'b0;
    tick();
    tests++;
    if (bus_err !== 1'b0 || err_master !== 3'd1) begin
      fails++;
      $display("FAIL to_pulse: err=%b err_master=%0d, need 0/1", bus_err, err_master);
    end
    leak = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (grant !== 8'h00) leak = 1'b1;
    end
    tests++;
    if (leak) begin
      fails++;
      $display("FAIL to_mask: masked master regranted, grant=%h need 00", grant);
    end
    DMA = 8'h00;
    tick();
    DMA = 8'h02;
    wait_grant(cyc, ok);
    tests++;
    if (!ok || grant !== 8'h02 || cyc != 1) begin
      fails++;
      $display("FAIL to_rearm: grant=%h latency=%0d, need 02/1", grant, cyc);
    end
    DMA = '0;
    tick();
    tick();
  endtask

  task automatic test_ready_boundary();
    int cyc;
    bit ok;
    bit bad;
    apply_reset();
    DMA = 8'h01;
    wait_grant(cyc, ok);
    for (int x = 0; x < 1000; x++) begin
      bad       = 1'b0;
      BUS_req   = 1'b1;
      BUS_ready = 1'b0;
      for (int k = 1; k < TO; k++) begin
        tick();
        if (bus_err !== 1'b0 || grant !== 8'h01) bad = 1'b1;
      end
      BUS_ready = 1'b1;
      tick();
      if (bus_err !== 1'b0 || grant !== 8'h01) bad = 1'b1;
      BUS_ready = 1'b0;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL ready_xfer%0d: err=%b grant=%h, need 0/01", x, bus_err, grant);
      end
    end
    BUS_req = 1'b0;
    tick();
    tests++;
    if (bus_err !== 1'b0 || grant !== 8'h01) begin
      fails++;
      $display("FAIL ready_final: err=%b grant=%h, need 0/01", bus_err, grant);
    end
    DMA = '0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    int cyc;
    bit ok;
    apply_reset();
    DMA = 8'h04;
    wait_grant(cyc, ok);
    BUS_req   = 1'b1;
    BUS_ready = 1'b0;
    for (int k = 1; k < TO; k++) tick();
    DMA = 8'h00;
    tick();
    tests++;
    if (bus_err !== 1'b1 || err_master !== 3'd2 || grant !== 8'h00) begin
      fails++;
      $display("FAIL sim_expire: err=%b err_master=%0d grant=%h, need 1/2/00", bus_err, err_master, grant);
    end
    BUS_req = 1'b0;
    tick();
    DMA = 8'h04;
    wait_grant(cyc, ok);
    tests++;
    if (!ok || grant !== 8'h04 || cyc != 1) begin
      fails++;
      $display("FAIL sim_unmask: grant=%h latency=%0d, need 04/1", grant, cyc);
    end
    DMA = '0;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    int         cyc;
    bit         ok;
    int         exp_o;
    logic [7:0] e;
    apply_reset();
    DMA = 8'hFF;
    for (int g = 0; g < 16; g++) begin
      exp_o = g % 8;
      e     = 8'h01 << exp_o;
      wait_grant(cyc, ok);
      tests++;
      if (!ok || grant !== e || owner !== 3'(exp_o)) begin
        fails++;
        $display("FAIL rot_order%0d: grant=%h owner=%0d, need %h/%0d", g, grant, owner, e, exp_o);
      end
      DMA[exp_o] = 1'b0;
      tick();
      tests++;
      if (!$onehot0(grant) || grant !== 8'h00) begin
        fails++;
        $display("FAIL rot_turn%0d: grant=%h, need 00", g, grant);
      end
      DMA[exp_o] = 1'b1;
    end
    DMA = '0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    int cyc;
    bit ok;
    apply_reset();
    DMA = 8'h08;
    wait_grant(cyc, ok);
    #3;
    clr_n = 1'b0;
    #1;
    tests++;
    if (grant !== 8'h00 || bus_busy !== 1'b0 || owner !== 3'd0) begin
      fails++;
      $display("FAIL areset_drop: grant=%h busy=%b owner=%0d, need 00/0/0", grant, bus_busy, owner);
    end
    DMA = 8'hFF;
    tick();
    clr_n = 1'b1;
    wait_grant(cyc, ok);
    tests++;
    if (!ok || grant !== 8'h01 || owner !== 3'd0 || cyc != 1) begin
      fails++;
      $display("FAIL areset_first: grant=%h owner=%0d latency=%0d, need 01/0/1", grant, owner, cyc);
    end
    DMA = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_ready_boundary();
    test_simultaneous();
    test_rotation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
